irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 30 +++
 rtl/irq_lat_cnt.sv | 40 ++++
 rtl/irq_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt/exception controller.
//   state_t : controller FSM states
//   cause_t : why the current redirect was taken
//   VEC_*_DEF : default handler addresses
//   epc_for() : return address to save for a given cause
// Optional feature macro used by the RTL: IRQ_CTRL_LATENCY_STAT_EN
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_TAKE    = 2'd2,
      ST_HANDLER = 2'd3
   } state_t;

   typedef enum logic {
      CAUSE_IRQ = 1'b0,
      CAUSE_EXC = 1'b1
   } cause_t;

   localparam logic [31:0] VEC_IRQ_DEF = 32'h8000_0004;
   localparam logic [31:0] VEC_EXC_DEF = 32'h8000_0008;

   // An interrupt re-executes the instruction in ID; an exception skips it.
   // The subtraction wraps modulo 2^32 by construction.
   function automatic logic [31:0] epc_for(input cause_t cause, input logic [31:0] pc4);
      return (cause == CAUSE_IRQ) ? (pc4 - 32'd4) : pc4;
   endfunction

endpackage

// File: rtl/irq_lat_cnt.sv
// Interrupt deferral latency statistic.
// Counts the cycles the controller spends in WAIT and keeps the largest
// count seen when an interrupt is finally taken from WAIT.
// Ports:
//   clk, reset_b      : clock, async active-low reset
//   wait_entry        : the next edge moves the FSM into WAIT
//   in_wait           : the FSM is in WAIT this cycle
//   take_from_wait    : the next edge moves the FSM from WAIT into TAKE
//   irq_lat_max[15:0] : largest WAIT residency observed, in cycles
module irq_lat_cnt (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        wait_entry,
   input  logic        in_wait,
   input  logic        take_from_wait,
   output logic [15:0] irq_lat_max
);

   logic [15:0] cnt;
   logic [15:0] cnt_inc;

   // cnt_inc already includes the current WAIT cycle, so on exit it equals
   // the number of cycles spent in WAIT.
   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cnt         <= '0;
         irq_lat_max <= '0;
      end else begin
         if (wait_entry)
            cnt <= '0;
         else if (in_wait)
            cnt <= cnt_inc;
         if (take_from_wait && (cnt_inc > irq_lat_max))
            irq_lat_max <= cnt_inc;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt / exception redirect controller for the in-order pipeline.
// Waits for a safe point in ID, issues a one-cycle redirect + flush, saves
// the return address and tracks handler (kernel) mode.
// Optional build macro: IRQ_CTRL_LATENCY_STAT_EN adds irq_lat_max.
// Ports:
//   clk, reset_b  : clock, async active-low reset
//   irq_req       : level interrupt from the timer
//   exc_req       : undefined-instruction flag for the instruction in ID
//   id_pc4        : PC+4 of the instruction in ID
//   id_valid      : ID holds a real instruction
//   stall         : load-use bubble this cycle
//   br_busy       : branch/jump unresolved in ID or EX
//   eret          : ID decodes return-from-handler
//   take, flush   : one-cycle redirect / pipeline flush pulse
//   vector        : redirect target, zero outside the pulse
//   irq_ack       : one-cycle pulse clearing the timer pending bit
//   epc           : saved return address
//   kernel        : handler mode
//   dbl_fault     : sticky, exception raised while in handler mode
//   irq_lat_max   : (macro only) longest deferral in WAIT, in cycles
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | user mode, nothing pending
// WAIT    | interrupt pending, waiting for a safe instruction in ID
// TAKE    | redirect/flush pulse cycle, epc already loaded
// HANDLER | kernel mode; irq masked, leaves on eret
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter logic [31:0] VEC_IRQ = VEC_IRQ_DEF,
   parameter logic [31:0] VEC_EXC = VEC_EXC_DEF
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        irq_req,
   input  logic        exc_req,
   input  logic [31:0] id_pc4,
   input  logic        id_valid,
   input  logic        stall,
   input  logic        br_busy,
   input  logic        eret,
   output logic        take,
   output logic [31:0] vector,
   output logic        flush,
   output logic        irq_ack,
   output logic [31:0] epc,
   output logic        kernel,
   output logic        dbl_fault
`ifdef IRQ_CTRL_LATENCY_STAT_EN
  ,output logic [15:0] irq_lat_max
`endif
);

   state_t state, state_nxt;
   cause_t cause, cause_nxt;
   logic   safe;
   logic   exc_hit;
   logic   eret_hit;

   assign safe     = id_valid & ~stall & ~br_busy;
   assign exc_hit  = exc_req & id_valid & ~stall;
   assign eret_hit = eret & id_valid & ~stall;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state     <= ST_IDLE;
         cause     <= CAUSE_IRQ;
         epc       <= '0;
         kernel    <= 1'b0;
         dbl_fault <= 1'b0;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
         if (state_nxt == ST_TAKE)
            epc <= epc_for(cause_nxt, id_pc4);
         if (state == ST_TAKE)
            kernel <= 1'b1;
         else if ((state == ST_HANDLER) && eret_hit)
            kernel <= 1'b0;
         if ((state == ST_HANDLER) && exc_req && id_valid)
            dbl_fault <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      case (state)
         ST_IDLE, ST_WAIT: begin
            if (exc_hit) begin
               state_nxt = ST_TAKE;
               cause_nxt = CAUSE_EXC;
            end else if (irq_req && safe) begin
               state_nxt = ST_TAKE;
               cause_nxt = CAUSE_IRQ;
            end else if (irq_req) begin
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_TAKE:    state_nxt = ST_HANDLER;
         ST_HANDLER: if (eret_hit) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Pulse outputs decode the state register directly, so an async reset
   // during TAKE kills them in the same cycle.
   always_comb begin
      take    = (state == ST_TAKE);
      flush   = take;
      irq_ack = take && (cause == CAUSE_IRQ);
      vector  = '0;
      if (take)
         vector = (cause == CAUSE_EXC) ? VEC_EXC : VEC_IRQ;
   end

`ifdef IRQ_CTRL_LATENCY_STAT_EN
   logic wait_entry;
   logic in_wait;
   logic take_from_wait;

   assign in_wait        = (state == ST_WAIT);
   assign wait_entry     = !in_wait && (state_nxt == ST_WAIT);
   assign take_from_wait = in_wait && (state_nxt == ST_TAKE);

   irq_lat_cnt u_lat_cnt (
      .clk            (clk),
      .reset_b        (reset_b),
      .wait_entry     (wait_entry),
      .in_wait        (in_wait),
      .take_from_wait (take_from_wait),
      .irq_lat_max    (irq_lat_max)
   );
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl. Expected redirects are queued
// when stimulus is applied and compared when the DUT pulses take.
module tb_irq_ctrl;

   logic        clk;
   logic        reset_b;
   logic        irq_req;
   logic        exc_req;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        stall;
   logic        br_busy;
   logic        eret;
   logic        take;
   logic [31:0] vector;
   logic        flush;
   logic        irq_ack;
   logic [31:0] epc;
   logic        kernel;
   logic        dbl_fault;
`ifdef IRQ_CTRL_LATENCY_STAT_EN
   logic [15:0] irq_lat_max;
`endif

   localparam logic [31:0] V_IRQ = 32'h8000_0004;
   localparam logic [31:0] V_EXC = 32'h8000_0008;

   typedef struct {
      logic [31:0] vec;
      logic        ack;
      logic [31:0] epc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   irq_ctrl dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .irq_req   (irq_req),
      .exc_req   (exc_req),
      .id_pc4    (id_pc4),
      .id_valid  (id_valid),
      .stall     (stall),
      .br_busy   (br_busy),
      .eret      (eret),
      .take      (take),
      .vector    (vector),
      .flush     (flush),
      .irq_ack   (irq_ack),
      .epc       (epc),
      .kernel    (kernel),
      .dbl_fault (dbl_fault)
`ifdef IRQ_CTRL_LATENCY_STAT_EN
     ,.irq_lat_max (irq_lat_max)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v, input logic a, input logic [31:0] e, input int l);
      exp_t x;
      x.vec = v;
      x.ack = a;
      x.epc = e;
      x.lat = l;
      sb.push_back(x);
   endtask

   // Wait (bounded) for the take pulse, then pop and compare the scoreboard.
   task automatic wait_take(input string tag);
      int   n;
      exp_t x;
      n = 0;
      do begin
         tick();
         n++;
      end while (!take && n < 20);
      chk({tag, "_take_seen"}, take, 1'b1);
      chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk({tag, "_latency"}, n, x.lat);
         chk({tag, "_vector"}, vector, x.vec);
         chk({tag, "_flush"}, flush, 1'b1);
         chk({tag, "_irq_ack"}, irq_ack, x.ack);
         chk({tag, "_epc"}, epc, x.epc);
      end
   endtask

   task automatic do_eret(input string tag);
      eret     = 1'b1;
      id_valid = 1'b1;
      tick();
      eret = 1'b0;
      chk({tag, "_kernel_after_eret"}, kernel, 1'b0);
   endtask

   initial begin
      reset_b  = 1'b0;
      irq_req  = 1'b0;
      exc_req  = 1'b0;
      id_pc4   = '0;
      id_valid = 1'b1;
      stall    = 1'b0;
      br_busy  = 1'b0;
      eret     = 1'b0;

      #3;
      chk("rst_take", take, 1'b0);
      chk("rst_vector", vector, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_kernel", kernel, 1'b0);
      chk("rst_dbl", dbl_fault, 1'b0);
      tick();
      reset_b = 1'b1;
      tick();

      // basic interrupt
      irq_req = 1'b1;
      id_pc4  = 32'h0000_0040;
      push(V_IRQ, 1'b1, 32'h0000_003C, 1);
      wait_take("basic");
      irq_req = 1'b0;
      tick();
      chk("basic_kernel", kernel, 1'b1);
      chk("basic_take_once", take, 1'b0);
      chk("basic_vector_idle", vector, 32'h0);
      chk("basic_epc_hold", epc, 32'h0000_003C);
      do_eret("basic");

      // deferred interrupt, branch busy for three edges
      irq_req = 1'b1;
      br_busy = 1'b1;
      id_pc4  = 32'h0000_0080;
      tick();
      chk("defer_no_take0", take, 1'b0);
      tick();
      tick();
      chk("defer_no_take2", take, 1'b0);
      chk("defer_epc_unchanged", epc, 32'h0000_003C);
      br_busy = 1'b0;
      push(V_IRQ, 1'b1, 32'h0000_007C, 1);
      wait_take("defer");
`ifdef IRQ_CTRL_LATENCY_STAT_EN
      chk("defer_lat_max", irq_lat_max, 32'd3);
`endif
      irq_req = 1'b0;
      tick();
      do_eret("defer");

      // pending irq withdrawn while waiting: no pulse
      irq_req = 1'b1;
      br_busy = 1'b1;
      tick();
      irq_req = 1'b0;
      tick();
      br_busy = 1'b0;
      tick();
      chk("withdraw_no_take", take, 1'b0);
      chk("withdraw_kernel", kernel, 1'b0);

      // simultaneous irq + exception: exception first, irq after eret
      irq_req = 1'b1;
      exc_req = 1'b1;
      id_pc4  = 32'h0000_0100;
      push(V_EXC, 1'b0, 32'h0000_0100, 1);
      wait_take("simul_exc");
      exc_req = 1'b0;
      tick();
      chk("simul_masked0", take, 1'b0);
      tick();
      chk("simul_masked1", take, 1'b0);
      chk("simul_kernel", kernel, 1'b1);
      id_pc4 = 32'h0000_0200;
      push(V_IRQ, 1'b1, 32'h0000_01FC, 1);
      do_eret("simul");
      wait_take("simul_irq");
      irq_req = 1'b0;
      tick();
      do_eret("simul_irq");

      // handler masking and double fault
      exc_req = 1'b1;
      id_pc4  = 32'h0000_0300;
      push(V_EXC, 1'b0, 32'h0000_0300, 1);
      wait_take("mask_exc");
      exc_req = 1'b0;
      tick();
      chk("mask_dbl_before", dbl_fault, 1'b0);
      for (int i = 0; i < 6; i++) begin
         irq_req = (i % 2 == 0);
         exc_req = (i == 3);
         tick();
         chk("mask_no_take", take, 1'b0);
      end
      irq_req = 1'b0;
      exc_req = 1'b0;
      chk("mask_dbl_set", dbl_fault, 1'b1);
      chk("mask_epc_hold", epc, 32'h0000_0300);
      do_eret("mask");
      tick();
      chk("mask_dbl_sticky", dbl_fault, 1'b1);
      chk("mask_no_take_after", take, 1'b0);

      // reset asserted during the TAKE cycle
      irq_req = 1'b1;
      id_pc4  = 32'h0000_0500;
      tick();
      chk("rstmid_take_on", take, 1'b1);
      reset_b = 1'b0;
      irq_req = 1'b0;
      #1;
      chk("rstmid_take", take, 1'b0);
      chk("rstmid_flush", flush, 1'b0);
      chk("rstmid_ack", irq_ack, 1'b0);
      chk("rstmid_vector", vector, 32'h0);
      chk("rstmid_epc", epc, 32'h0);
      chk("rstmid_kernel", kernel, 1'b0);
      chk("rstmid_dbl", dbl_fault, 1'b0);
      tick();
      reset_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstmid_no_redirect", take, 1'b0);
         chk("rstmid_kernel_after", kernel, 1'b0);
      end

      // epc wrap at address zero
      irq_req = 1'b1;
      id_pc4  = 32'h0000_0000;
      push(V_IRQ, 1'b1, 32'hFFFF_FFFC, 1);
      wait_take("wrap");
      irq_req = 1'b0;
      tick();
      do_eret("wrap");

      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
